// File: rtl/imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// imem_fetch_ctrl
//
// Instruction-fetch sequencer for the combinational, word-indexed instruction
// memory of the RISC-V core. It owns the fetch PC, issues one memory read per
// cycle, and buffers fetched words in a small FIFO toward decode. Branch/jump
// redirects flush the buffer and restart fetch. A debug read requester shares
// the memory port; it wins whenever fetch is idle, and after DBG_STARVE
// consecutive denied cycles it is forced a grant over fetch.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   imem_addr      word index presented to instruction memory
//   imem_rdata     combinational instruction word for imem_addr
//   redirect_valid one-cycle pulse: flush and restart fetch at redirect_pc
//   redirect_pc    new byte PC (bits [1:0] ignored)
//   out_valid      FIFO head holds a valid instruction
//   out_ready      decode accepts the head this cycle
//   out_instr      instruction at FIFO head
//   out_pc         byte PC of out_instr
//   halted         fetch stopped at end of memory and FIFO empty
//   dbg_req        debug read request, held until granted
//   dbg_addr       debug word index
//   dbg_gnt        combinational debug grant
//   dbg_rdata      memory data for the debug read when granted, else 0
// ---------------------------------------------------------------------------
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned DEPTH      = 100,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned DBG_STARVE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        halted,
    input  logic        dbg_req,
    input  logic [31:0] dbg_addr,
    output logic        dbg_gnt,
    output logic [31:0] dbg_rdata
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SW = (DBG_STARVE > 0) ? $clog2(DBG_STARVE + 1) : 1;

    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] STARVE_MAX = SW'(DBG_STARVE);
    localparam logic [31:0]   DEPTH_W    = 32'(DEPTH);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   fifo_instr [FIFO_DEPTH];
    logic [31:0]   fifo_pc    [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [SW-1:0] starve_cnt;

    logic [31:0]   fetch_idx;
    logic [31:0]   next_pc;
    logic [31:0]   next_idx;
    logic          in_range;
    logic          fifo_full;
    logic          pop;
    logic          can_fetch;
    logic          push;

    // Fetch-side bookkeeping. A RUN state whose PC is already past the end
    // of memory (possible right after a redirect) never fetches, so no word
    // at index >= DEPTH can ever reach the FIFO.
    assign fetch_idx = {2'b00, fetch_pc[31:2]};
    assign next_pc   = fetch_pc + 32'd4;
    assign next_idx  = {2'b00, next_pc[31:2]};
    assign in_range  = (fetch_idx < DEPTH_W);
    assign fifo_full = (count == FULL_COUNT);
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign can_fetch = (state == RUN) && in_range && !redirect_valid
                       && (!fifo_full || pop);

    // Port arbitration: debug takes the port whenever fetch would not use
    // it, or when it has been starved long enough. Gating with rst_n keeps
    // the grant low while the block is held in reset.
    assign dbg_gnt   = rst_n && dbg_req
                       && (!can_fetch || (starve_cnt == STARVE_MAX));
    assign push      = can_fetch && !dbg_gnt;
    assign imem_addr = dbg_gnt ? dbg_addr : fetch_idx;
    assign dbg_rdata = dbg_gnt ? imem_rdata : 32'd0;

    assign out_instr = fifo_instr[rd_ptr];
    assign out_pc    = fifo_pc[rd_ptr];
    assign halted    = (state == HALT) && !out_valid;

    // Control FSM, fetch PC and debug starvation counter. A redirect always
    // wins over a fetch; the PC advance and the HALT decision happen together
    // so the word at DEPTH-1 is the last one ever pushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            fetch_pc   <= RESET_PC;
            starve_cnt <= '0;
        end else begin
            if (redirect_valid) begin
                fetch_pc <= redirect_pc & ~32'h0000_0003;
                state    <= RUN;
            end else if (push) begin
                fetch_pc <= next_pc;
                if (next_idx >= DEPTH_W) begin
                    state <= HALT;
                end
            end else if ((state == RUN) && !in_range) begin
                state <= HALT;
            end

            if (dbg_req && !dbg_gnt) begin
                if (starve_cnt != STARVE_MAX) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end else begin
                starve_cnt <= '0;
            end
        end
    end

    // FIFO pointers and occupancy. A redirect discards every entry, even one
    // popped in the same cycle. Push and pop together leave the count alone,
    // which also covers the full case since the popped slot is the one
    // being rewritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // FIFO storage; contents are only meaningful where count says so, so no
    // reset is needed on the data.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]    <= fetch_pc;
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_imem_fetch_ctrl
//
// Directed bench for imem_fetch_ctrl. Two instances share clock and reset:
// u_dut with the default DEPTH and u_small with DEPTH = 4 for end-of-memory
// behaviour. Each instance reads a memory model whose word at index i is
// 32'hCAFE_0000 ^ i, so expected instructions follow directly from the PC.
// ---------------------------------------------------------------------------
module tb_imem_fetch_ctrl;

    logic        clk;
    logic        rst_n;

    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;
    logic        dbg_req;
    logic [31:0] dbg_addr;
    logic        dbg_gnt;
    logic [31:0] dbg_rdata;

    logic [31:0] s_imem_addr;
    logic [31:0] s_imem_rdata;
    logic        s_redirect_valid;
    logic [31:0] s_redirect_pc;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [31:0] s_out_instr;
    logic [31:0] s_out_pc;
    logic        s_halted;
    logic        s_dbg_req;
    logic [31:0] s_dbg_addr;
    logic        s_dbg_gnt;
    logic [31:0] s_dbg_rdata;

    int checks;
    int errors;

    imem_fetch_ctrl u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted),
        .dbg_req        (dbg_req),
        .dbg_addr       (dbg_addr),
        .dbg_gnt        (dbg_gnt),
        .dbg_rdata      (dbg_rdata)
    );

    imem_fetch_ctrl #(.DEPTH(4)) u_small (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (s_imem_addr),
        .imem_rdata     (s_imem_rdata),
        .redirect_valid (s_redirect_valid),
        .redirect_pc    (s_redirect_pc),
        .out_valid      (s_out_valid),
        .out_ready      (s_out_ready),
        .out_instr      (s_out_instr),
        .out_pc         (s_out_pc),
        .halted         (s_halted),
        .dbg_req        (s_dbg_req),
        .dbg_addr       (s_dbg_addr),
        .dbg_gnt        (s_dbg_gnt),
        .dbg_rdata      (s_dbg_rdata)
    );

    // Combinational instruction memory models
    assign imem_rdata   = 32'hCAFE_0000 ^ imem_addr;
    assign s_imem_rdata = 32'hCAFE_0000 ^ s_imem_addr;

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive the main instance's inputs in one go
    task automatic applyStimulus(input logic ready, input logic rv,
                                 input logic [31:0] rpc, input logic dreq,
                                 input logic [31:0] daddr);
        out_ready      = ready;
        redirect_valid = rv;
        redirect_pc    = rpc;
        dbg_req        = dreq;
        dbg_addr       = daddr;
    endtask

    // One comparison: counts it, and on mismatch counts and reports it
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance through one rising edge and stop on the following falling edge
    task automatic clockCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Directed test sequence
    initial begin
        checks           = 0;
        errors           = 0;
        rst_n            = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'd3);
        s_out_ready      = 1'b0;
        s_redirect_valid = 1'b0;
        s_redirect_pc    = 32'd0;
        s_dbg_req        = 1'b0;
        s_dbg_addr       = 32'd0;

        // Outputs while held in reset, with a debug request pending
        #2;
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_halted", {31'd0, halted}, 32'd0);
        checkOutput("rst_dbg_gnt", {31'd0, dbg_gnt}, 32'd0);

        // Streaming fetch with decode always ready
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        rst_n = 1'b1;
        $display("[TB] streaming fetch");
        for (int i = 0; i < 4; i++) begin
            clockCycle();
            checkOutput("stream_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("stream_pc", out_pc, 32'(4 * i));
            checkOutput("stream_instr", out_instr, 32'hCAFE_0000 | 32'(i));
        end
        checkOutput("stream_addr", imem_addr, 32'd4);

        // Reset mid-operation, then back-pressure from decode
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", {31'd0, out_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        rst_n = 1'b1;
        $display("[TB] back-pressure");
        repeat (5) clockCycle();
        checkOutput("stall_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("stall_pc", out_pc, 32'd0);
        checkOutput("stall_instr", out_instr, 32'hCAFE_0000);
        checkOutput("stall_addr", imem_addr, 32'd2);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        clockCycle();
        checkOutput("resume_pc_b", out_pc, 32'd4);
        checkOutput("resume_instr_b", out_instr, 32'hCAFE_0001);
        clockCycle();
        checkOutput("resume_pc_c", out_pc, 32'd8);
        checkOutput("resume_instr_c", out_instr, 32'hCAFE_0002);
        clockCycle();
        checkOutput("resume_pc_d", out_pc, 32'd12);

        // Redirects with a full FIFO, aligned and unaligned targets
        $display("[TB] redirect");
        applyStimulus(1'b0, 1'b1, 32'h40, 1'b0, 32'd0);
        clockCycle();
        checkOutput("redir_flush_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("redir_addr", imem_addr, 32'h10);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        clockCycle();
        checkOutput("redir_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("redir_pc", out_pc, 32'h40);
        checkOutput("redir_instr", out_instr, 32'hCAFE_0010);
        applyStimulus(1'b0, 1'b1, 32'h43, 1'b0, 32'd0);
        clockCycle();
        checkOutput("redir43_flush", {31'd0, out_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        clockCycle();
        checkOutput("redir43_pc", out_pc, 32'h40);

        // Debug read while fetch is blocked by a full FIFO
        $display("[TB] debug while blocked");
        clockCycle();
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'd2);
        #1;
        checkOutput("dbg_blk_gnt", {31'd0, dbg_gnt}, 32'd1);
        checkOutput("dbg_blk_rdata", dbg_rdata, 32'hCAFE_0002);
        checkOutput("dbg_blk_addr", imem_addr, 32'd2);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd2);
        #1;
        checkOutput("dbg_idle_gnt", {31'd0, dbg_gnt}, 32'd0);
        checkOutput("dbg_idle_rdata", dbg_rdata, 32'd0);
        checkOutput("dbg_idle_addr", imem_addr, 32'h12);
        clockCycle();
        checkOutput("dbg_hold_pc", out_pc, 32'h40);

        // Debug starvation: fetch wins four cycles, debug forced on the fifth
        $display("[TB] debug starvation");
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 32'd5);
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput("starve_gnt", {31'd0, dbg_gnt}, 32'd0);
            checkOutput("starve_addr", imem_addr, 32'h12 + 32'(i));
            clockCycle();
        end
        #1;
        checkOutput("forced_gnt", {31'd0, dbg_gnt}, 32'd1);
        checkOutput("forced_rdata", dbg_rdata, 32'hCAFE_0005);
        checkOutput("forced_addr", imem_addr, 32'd5);
        clockCycle();
        checkOutput("forced_out_pc", out_pc, 32'h54);
        checkOutput("forced_out_instr", out_instr, 32'hCAFE_0015);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        #1;
        checkOutput("after_forced_addr", imem_addr, 32'h16);
        clockCycle();
        checkOutput("after_forced_pc1", out_pc, 32'h58);
        clockCycle();
        checkOutput("after_forced_pc2", out_pc, 32'h5C);
        checkOutput("after_forced_instr2", out_instr, 32'hCAFE_0017);

        // End of memory on the DEPTH = 4 instance
        $display("[TB] end of memory");
        s_out_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            clockCycle();
            checkOutput("eom_valid", {31'd0, s_out_valid}, 32'd1);
            checkOutput("eom_pc", s_out_pc, 32'(4 * i));
            checkOutput("eom_instr", s_out_instr, 32'hCAFE_0000 | 32'(i));
        end
        checkOutput("eom_not_halted", {31'd0, s_halted}, 32'd0);
        clockCycle();
        checkOutput("eom_halted", {31'd0, s_halted}, 32'd1);
        checkOutput("eom_drained", {31'd0, s_out_valid}, 32'd0);
        clockCycle();
        checkOutput("eom_still_halted", {31'd0, s_halted}, 32'd1);
        checkOutput("eom_still_invalid", {31'd0, s_out_valid}, 32'd0);
        checkOutput("eom_addr", s_imem_addr, 32'd4);
        checkOutput("eom_dbg_gnt", {31'd0, s_dbg_gnt}, 32'd0);
        checkOutput("eom_dbg_rdata", s_dbg_rdata, 32'd0);
        s_redirect_valid = 1'b1;
        s_redirect_pc    = 32'd0;
        clockCycle();
        checkOutput("eom_redir_halted", {31'd0, s_halted}, 32'd0);
        checkOutput("eom_redir_valid", {31'd0, s_out_valid}, 32'd0);
        s_redirect_valid = 1'b0;
        clockCycle();
        checkOutput("eom_resume_valid", {31'd0, s_out_valid}, 32'd1);
        checkOutput("eom_resume_pc", s_out_pc, 32'd0);
        checkOutput("eom_resume_instr", s_out_instr, 32'hCAFE_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Instruction-fetch sequencer for the combinational, word-indexed instruction memory of the RISC-V core.
- Owns the fetch PC and drives the memory word address.
- Buffers fetched instructions in a small FIFO toward decode with a valid/ready handshake.
- Handles branch/jump redirects and shares the memory read port with a debug read requester.

Parameters:
- RESET_PC, 32'h0000_0000, byte address fetched first after reset.
- DEPTH, 100, number of 32-bit words in instruction memory; fetch stops at word index DEPTH.
- FIFO_DEPTH, 2, instruction buffer entries (power of two, ≥2).
- DBG_STARVE, 4, consecutive denied debug cycles before debug is forced a grant.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_addr  output  32  word index to instruction memory; equals port_pc[31:2] zero-extended.
- imem_rdata  input  32  combinational instruction word for imem_addr (same cycle).
- redirect_valid  input  1  one-cycle pulse: flush and restart fetch at redirect_pc.
- redirect_pc  input  32  new byte PC; bits [1:0] ignored (treated as 0).
- out_valid  output  1  FIFO head holds a valid instruction.
- out_ready  input  1  decode accepts the head this cycle.
- out_instr  output  32  instruction at FIFO head.
- out_pc  output  32  byte PC of out_instr.
- halted  output  1  fetch stopped at the end of memory and FIFO is empty.
- dbg_req  input  1  debug read request; held until granted.
- dbg_addr  input  32  debug word index.
- dbg_gnt  output  1  combinational grant; dbg_rdata is valid in the same cycle.
- dbg_rdata  output  32  equals imem_rdata when dbg_gnt = 1, else 0.

Behaviour:
- Clocking/reset:
  - Single clock. rst_n low asynchronously sets fetch_pc = RESET_PC, FIFO empty, state RUN, starve counter 0.
  - Outputs during reset: out_valid = 0, halted = 0, dbg_gnt = 0.
- States:
  - RUN: fetching.
  - HALT: fetch_pc[31:2] ≥ DEPTH; no fetches issued.
  - RUN→HALT when the fetch_pc update produces a word index ≥ DEPTH.
  - HALT→RUN only on redirect_valid.
  - halted = (state == HALT) && FIFO empty.
- pop = out_valid && out_ready.
- can_fetch = state RUN && !redirect_valid && (FIFO not full || pop).
- Memory port arbitration (one read per cycle):
  - If dbg_req && (!can_fetch || starve_cnt == DBG_STARVE): dbg_gnt = 1, imem_addr = dbg_addr, no fetch this cycle.
  - Otherwise, if can_fetch: imem_addr = fetch_pc[31:2]; at the clock edge {fetch_pc, imem_rdata} is pushed and fetch_pc += 4 (32-bit wrap).
- Starve counter:
  - Increments while dbg_req is high and not granted, saturating at DBG_STARVE.
  - Clears on grant or when dbg_req is low.
- Output timing:
  - Zero-latency fetch: an instruction pushed at edge N is visible on out_* after edge N.
  - out_* come from the FIFO head. out_instr and out_pc hold stable while out_valid && !out_ready.
- Simultaneous push and pop with the FIFO full is legal; occupancy is unchanged.
- Redirect:
  - At the edge, flush all entries, set fetch_pc = {redirect_pc[31:2], 2'b00}, state RUN. No push occurs that cycle.
  - A pop in the same cycle still counts as consumed, but the flush discards everything.
  - First post-redirect instruction appears one cycle after the redirect edge.
- Debug grant in the redirect cycle is permitted (the port is otherwise idle).
- out_valid is never asserted for a word index ≥ DEPTH.
- Reset mid-operation discards FIFO contents and any pending debug request state.

Test Plan:
- Reset release, out_ready = 1, memory words 0..3 = A, B, C, D → out_pc/out_instr = 0/A, 4/B, 8/C, 12/D on consecutive cycles starting the cycle after the first edge.
- out_ready = 0 for 5 cycles after reset → FIFO holds PCs 0 and 4, fetch_pc stalls at 8, out_instr stays A. Then out_ready = 1 → B, then C with no gaps and no duplicates.
- Redirect to 0x40 while the FIFO holds 2 entries → both dropped. The next valid output is pc 0x40 one cycle later. redirect_pc = 0x43 gives pc 0x40.
- DEPTH = 4, out_ready = 1 → PCs 0, 4, 8, 12 emitted, then halted = 1 and out_valid stays 0. Redirect to 0 → halted = 0 and fetch resumes at 0.
- dbg_req with dbg_addr = 2 while the FIFO is full and out_ready = 0 → dbg_gnt = 1 the same cycle and dbg_rdata = word 2.
- dbg_req held while out_ready = 1 → fetch wins for 4 cycles, dbg_gnt on the 5th. That cycle has no push and the fetch PC sequence continues without a gap in values.
